// File: rtl/vend_seq.sv
// Vending sequencer: debounced coin input, credit accounting, dispense handshake and refunds.
// Define VEND_TIMEOUT_EN to build in the dispense-acknowledge timeout and sticky fault flag.
module vend_seq #(
    parameter int PRICE       = 3,
    parameter int MAX_CREDIT  = 7,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_raw,
    input  logic       sel,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       refund_pulse,
    output logic       coin_reject,
    output logic [2:0] credit,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CREDIT   = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3,
        REFUND   = 3'd4
    } state_t;

    localparam logic [2:0] W_PRICE = 3'(PRICE);
    localparam logic [2:0] W_MAX   = 3'(MAX_CREDIT);

    state_t     r_state;
    state_t     w_stateNext;
    logic [2:0] r_credit;
    logic [2:0] w_creditNext;
    logic [2:0] r_sync;
    logic       r_debPrev;
    logic       r_phase;
    logic       w_phaseNext;
    logic       r_coinReject;
    logic       w_coinRejectNext;
    logic       w_deb;
    logic       w_coinEv;
    logic       w_timeout;

    // A coin counts only once the sensor has read high on three consecutive samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 3'b000;
            r_debPrev <= 1'b0;
        end else begin
            r_sync    <= {r_sync[1:0], coin_raw};
            r_debPrev <= w_deb;
        end
    end

    assign w_deb    = &r_sync;
    assign w_coinEv = w_deb & ~r_debPrev;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_tmoCnt;
    logic          r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmoCnt <= '0;
            r_fault  <= 1'b0;
        end else begin
            if (r_state == DISPENSE && !disp_ack) begin
                r_tmoCnt <= r_tmoCnt + 1'b1;
            end else begin
                r_tmoCnt <= '0;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign w_timeout = (r_state == DISPENSE) && !disp_ack &&
                       (r_tmoCnt == TW'(TIMEOUT_CYC - 1));
    assign fault     = r_fault;
`else
    // TIMEOUT_CYC only matters when the timeout is built in.
    logic w_unusedTimeoutCfg;
    assign w_unusedTimeoutCfg = (TIMEOUT_CYC > 0);
    assign w_timeout          = 1'b0;
    assign fault              = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_credit     <= 3'd0;
            r_phase      <= 1'b0;
            r_coinReject <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_credit     <= w_creditNext;
            r_phase      <= w_phaseNext;
            r_coinReject <= w_coinRejectNext;
        end
    end

    // r_phase marks the quiet cycle that follows each refund pulse.
    always_comb begin
        w_stateNext      = r_state;
        w_creditNext     = r_credit;
        w_phaseNext      = 1'b0;
        w_coinRejectNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_coinEv) begin
                    w_creditNext = 3'd1;
                    w_stateNext  = CREDIT;
                end
            end
            CREDIT: begin
                if (cancel) begin
                    w_stateNext      = REFUND;
                    w_coinRejectNext = w_coinEv;
                end else if (sel && (r_credit >= W_PRICE)) begin
                    w_creditNext     = r_credit - W_PRICE;
                    w_stateNext      = DISPENSE;
                    w_coinRejectNext = w_coinEv;
                end else if (w_coinEv) begin
                    if (r_credit >= W_MAX) begin
                        w_coinRejectNext = 1'b1;
                    end else begin
                        w_creditNext = r_credit + 3'd1;
                    end
                end
            end
            DISPENSE: begin
                w_coinRejectNext = w_coinEv;
                if (disp_ack) begin
                    w_stateNext = (r_credit != 3'd0) ? CHANGE : IDLE;
                end else if (w_timeout) begin
                    w_creditNext = r_credit + W_PRICE;
                    w_stateNext  = REFUND;
                end
            end
            CHANGE, REFUND: begin
                w_coinRejectNext = w_coinEv;
                if (r_credit == 3'd0) begin
                    w_stateNext = IDLE;
                end else if (!r_phase) begin
                    w_creditNext = r_credit - 3'd1;
                    if (r_credit == 3'd1) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_phaseNext = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext  = IDLE;
                w_creditNext = 3'd0;
            end
        endcase
    end

    assign disp_req     = (r_state == DISPENSE);
    assign refund_pulse = ((r_state == CHANGE) || (r_state == REFUND)) &&
                          !r_phase && (r_credit != 3'd0);
    assign coin_reject  = r_coinReject;
    assign credit       = r_credit;
    assign state        = r_state;

endmodule

// File: tb/tb_vend_seq.sv
// Self-checking bench for vend_seq: directed scenarios plus randomized traffic against a
// behavioural model. Mirrors VEND_TIMEOUT_EN so both builds are checked.
module tb_vend_seq;

    localparam int PRICE       = 3;
    localparam int MAX_CREDIT  = 7;
    localparam int TIMEOUT_CYC = 20;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       coin_raw = 1'b0;
    logic       sel      = 1'b0;
    logic       cancel   = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req;
    logic       refund_pulse;
    logic       coin_reject;
    logic       fault;
    logic [2:0] credit;
    logic [2:0] state;

    int nChecks = 0;
    int nErrors = 0;

    // Model: mode uses the published state codes, mElapsed counts cycles spent in the mode.
    int       mMode;
    int       mCredit;
    int       mElapsed;
    bit       mReject;
    bit       mFault;
    bit [3:0] mSamp;

    int seenDisp;
    int seenRefund;
    int seenReject;
    int cycleNo = 0;

    vend_seq #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_raw    (coin_raw),
        .sel         (sel),
        .cancel      (cancel),
        .disp_ack    (disp_ack),
        .disp_req    (disp_req),
        .refund_pulse(refund_pulse),
        .coin_reject (coin_reject),
        .credit      (credit),
        .state       (state),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        mMode    = 0;
        mCredit  = 0;
        mElapsed = 0;
        mReject  = 1'b0;
        mFault   = 1'b0;
        mSamp    = 4'b0000;
    endtask

    task automatic modelStep(input bit c, input bit s, input bit x, input bit a);
        bit ev;
        ev = mSamp[0] && mSamp[1] && mSamp[2] && !(mSamp[1] && mSamp[2] && mSamp[3]);
        mReject = 1'b0;
        case (mMode)
            0: if (ev) begin mCredit = 1; mMode = 1; end
            1: begin
                if (x) begin
                    mMode = 4; mElapsed = 0; mReject = ev;
                end else if (s && mCredit >= PRICE) begin
                    mCredit -= PRICE; mMode = 2; mElapsed = 0; mReject = ev;
                end else if (ev) begin
                    if (mCredit == MAX_CREDIT) mReject = 1'b1;
                    else mCredit++;
                end
            end
            2: begin
                mReject = ev;
                if (a) begin
                    mMode = (mCredit > 0) ? 3 : 0; mElapsed = 0;
                end
`ifdef VEND_TIMEOUT_EN
                else if (mElapsed == TIMEOUT_CYC - 1) begin
                    mFault = 1'b1; mCredit += PRICE; mMode = 4; mElapsed = 0;
                end
`endif
                else mElapsed++;
            end
            default: begin
                mReject = ev;
                if (mCredit == 0) mMode = 0;
                else begin
                    if (mElapsed % 2 == 0) begin
                        mCredit--;
                        if (mCredit == 0) mMode = 0;
                    end
                    mElapsed++;
                end
            end
        endcase
        mSamp = {mSamp[2:0], c};
    endtask

    // Drives one clock cycle of inputs, advances the model and tallies observed pulses.
    task automatic applyStimulus(input bit c, input bit s, input bit x, input bit a);
        coin_raw = c; sel = s; cancel = x; disp_ack = a;
        @(posedge clk);
        modelStep(c, s, x, a);
        @(negedge clk);
        cycleNo++;
        if (disp_req === 1'b1)     seenDisp++;
        if (refund_pulse === 1'b1) seenRefund++;
        if (coin_reject === 1'b1)  seenReject++;
    endtask

    task automatic insertCoin();
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst_n = 1'b0; coin_raw = 1'b0; sel = 1'b0; cancel = 1'b0; disp_ack = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        nChecks++; if (state !== 3'd0) begin nErrors++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        nChecks++; if (credit !== 3'd0) begin nErrors++; $display("[TB] FAIL reset_credit: got %0d want 0", credit); end
        nChecks++; if (disp_req !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_disp_req: got %b want 0", disp_req); end
        nChecks++; if (refund_pulse !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_refund: got %b want 0", refund_pulse); end
        nChecks++; if (coin_reject !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_reject: got %b want 0", coin_reject); end
        nChecks++; if (fault !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_fault: got %b want 0", fault); end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_coin_steps();
        doReset();
        for (int k = 1; k <= 4; k++) begin
            insertCoin();
            nChecks++;
            if (credit !== 3'(k)) begin nErrors++; $display("[TB] FAIL coin_step%0d: credit got %0d want %0d", k, credit, k); end
        end
        seenDisp = 0; seenRefund = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        nChecks++; if (state !== 3'd2) begin nErrors++; $display("[TB] FAIL steps_dispense_state: got %0d want 2", state); end
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (seenDisp != 6) begin nErrors++; $display("[TB] FAIL steps_disp_cycles: got %0d want 6", seenDisp); end
        nChecks++; if (seenRefund != 1) begin nErrors++; $display("[TB] FAIL steps_refunds: got %0d want 1", seenRefund); end
        nChecks++; if (credit !== 3'd0) begin nErrors++; $display("[TB] FAIL steps_final_credit: got %0d want 0", credit); end
        nChecks++; if (state !== 3'd0) begin nErrors++; $display("[TB] FAIL steps_final_state: got %0d want 0", state); end
    endtask

    task automatic test_bounce();
        doReset();
        seenReject = 0;
        for (int i = 0; i < 10; i++) applyStimulus((i % 2) == 0, 1'b0, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (credit !== 3'd1) begin nErrors++; $display("[TB] FAIL bounce_credit: got %0d want 1", credit); end
        nChecks++; if (state !== 3'd1) begin nErrors++; $display("[TB] FAIL bounce_state: got %0d want 1", state); end
        nChecks++; if (seenReject != 0) begin nErrors++; $display("[TB] FAIL bounce_rejects: got %0d want 0", seenReject); end
    endtask

    task automatic test_saturation();
        int last;
        doReset();
        seenReject = 0;
        repeat (8) insertCoin();
        nChecks++; if (credit !== 3'd7) begin nErrors++; $display("[TB] FAIL sat_credit: got %0d want 7", credit); end
        nChecks++; if (seenReject != 1) begin nErrors++; $display("[TB] FAIL sat_rejects: got %0d want 1", seenReject); end
        seenRefund = 0;
        last = -1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, i == 0, 1'b0);
            if (refund_pulse === 1'b1) begin
                if (last >= 0) begin
                    nChecks++;
                    if (cycleNo - last != 2) begin nErrors++; $display("[TB] FAIL sat_spacing: got %0d want 2", cycleNo - last); end
                end
                last = cycleNo;
            end
        end
        nChecks++; if (seenRefund != 7) begin nErrors++; $display("[TB] FAIL sat_refunds: got %0d want 7", seenRefund); end
        nChecks++; if (state !== 3'd0) begin nErrors++; $display("[TB] FAIL sat_final_state: got %0d want 0", state); end
        nChecks++; if (credit !== 3'd0) begin nErrors++; $display("[TB] FAIL sat_final_credit: got %0d want 0", credit); end
    endtask

    task automatic test_simultaneous();
        doReset();
        repeat (3) insertCoin();
        seenDisp = 0; seenRefund = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        nChecks++; if (state !== 3'd4) begin nErrors++; $display("[TB] FAIL simul_state: got %0d want 4", state); end
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (seenDisp != 0) begin nErrors++; $display("[TB] FAIL simul_disp: got %0d want 0", seenDisp); end
        nChecks++; if (seenRefund != 3) begin nErrors++; $display("[TB] FAIL simul_refunds: got %0d want 3", seenRefund); end
        nChecks++; if (state !== 3'd0) begin nErrors++; $display("[TB] FAIL simul_final_state: got %0d want 0", state); end
    endtask

    task automatic test_dispense_wait();
        doReset();
        repeat (3) insertCoin();
        seenDisp = 0; seenRefund = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (30) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef VEND_TIMEOUT_EN
        nChecks++; if (seenDisp != TIMEOUT_CYC) begin nErrors++; $display("[TB] FAIL tmo_disp_cycles: got %0d want %0d", seenDisp, TIMEOUT_CYC); end
        nChecks++; if (fault !== 1'b1) begin nErrors++; $display("[TB] FAIL tmo_fault: got %b want 1", fault); end
        nChecks++; if (seenRefund != 3) begin nErrors++; $display("[TB] FAIL tmo_refunds: got %0d want 3", seenRefund); end
        nChecks++; if (state !== 3'd0) begin nErrors++; $display("[TB] FAIL tmo_final_state: got %0d want 0", state); end
`else
        nChecks++; if (seenDisp != 31) begin nErrors++; $display("[TB] FAIL wait_disp_cycles: got %0d want 31", seenDisp); end
        nChecks++; if (fault !== 1'b0) begin nErrors++; $display("[TB] FAIL wait_fault: got %b want 0", fault); end
        nChecks++; if (state !== 3'd2) begin nErrors++; $display("[TB] FAIL wait_state: got %0d want 2", state); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        nChecks++; if (state !== 3'd0) begin nErrors++; $display("[TB] FAIL wait_ack_state: got %0d want 0", state); end
`endif
        nChecks++; if (credit !== 3'd0) begin nErrors++; $display("[TB] FAIL wait_final_credit: got %0d want 0", credit); end
    endtask

    task automatic test_reset_midchange();
        doReset();
        repeat (6) insertCoin();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (credit !== 3'd2) begin nErrors++; $display("[TB] FAIL mid_credit: got %0d want 2", credit); end
        nChecks++; if (state !== 3'd3) begin nErrors++; $display("[TB] FAIL mid_state: got %0d want 3", state); end
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++; if (state !== 3'd0) begin nErrors++; $display("[TB] FAIL async_state: got %0d want 0", state); end
        nChecks++; if (credit !== 3'd0) begin nErrors++; $display("[TB] FAIL async_credit: got %0d want 0", credit); end
        nChecks++; if ({disp_req, refund_pulse, coin_reject, fault} !== 4'b0000) begin
            nErrors++; $display("[TB] FAIL async_outputs: got %b want 0000", {disp_req, refund_pulse, coin_reject, fault});
        end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        seenRefund = 0;
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        nChecks++; if (seenRefund != 0) begin nErrors++; $display("[TB] FAIL mid_post_refunds: got %0d want 0", seenRefund); end
        nChecks++; if (credit !== 3'd0) begin nErrors++; $display("[TB] FAIL mid_post_credit: got %0d want 0", credit); end
    endtask

    task automatic test_raw_through_reset();
        rst_n = 1'b0; coin_raw = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        nChecks++; if (credit !== 3'd0) begin nErrors++; $display("[TB] FAIL held_early_credit: got %0d want 0", credit); end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        nChecks++; if (credit !== 3'd1) begin nErrors++; $display("[TB] FAIL held_credit: got %0d want 1", credit); end
    endtask

    task automatic test_random();
        bit coinLvl;
        int holdLeft;
        doReset();
        coinLvl = 1'b0;
        holdLeft = 0;
        for (int i = 0; i < 600; i++) begin
            if (holdLeft == 0) begin
                coinLvl  = ~coinLvl;
                holdLeft = $urandom_range(1, 6);
            end
            holdLeft--;
            applyStimulus(coinLvl, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 4) == 0);
            nChecks++; if (state !== 3'(mMode)) begin nErrors++; $display("[TB] FAIL rand_state cyc %0d: got %0d want %0d", i, state, mMode); end
            nChecks++; if (credit !== 3'(mCredit)) begin nErrors++; $display("[TB] FAIL rand_credit cyc %0d: got %0d want %0d", i, credit, mCredit); end
            nChecks++; if (disp_req !== (mMode == 2)) begin nErrors++; $display("[TB] FAIL rand_disp_req cyc %0d: got %b want %b", i, disp_req, mMode == 2); end
            nChecks++;
            if (refund_pulse !== ((mMode >= 3) && (mElapsed % 2 == 0) && (mCredit > 0))) begin
                nErrors++; $display("[TB] FAIL rand_refund cyc %0d: got %b", i, refund_pulse);
            end
            nChecks++; if (coin_reject !== mReject) begin nErrors++; $display("[TB] FAIL rand_reject cyc %0d: got %b want %b", i, coin_reject, mReject); end
            nChecks++; if (fault !== mFault) begin nErrors++; $display("[TB] FAIL rand_fault cyc %0d: got %b want %b", i, fault, mFault); end
        end
    endtask

    initial begin
        test_reset();
        test_coin_steps();
        test_bounce();
        test_saturation();
        test_simultaneous();
        test_dispense_wait();
        test_reset_midchange();
        test_raw_through_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
